// File: rtl/barrelshifter_arbiter.sv
// Round-robin arbiter that shares one combinational barrel shifter between N_REQ requesters.
// Define BSARB_FIXED_PRIO_EN to build a fixed-priority arbiter (lowest index wins) instead.

// op: 0 sll, 1 srl, 2 sra, 3 rol, 4 ror, 5-7 pass; vf flags nonzero bits lost by sll/srl.
module barrelshifter_comb_structural #(
  parameter int D_SIZE = 8,
  parameter int S      = $clog2(D_SIZE)
) (
  input  logic              rst_in,
  input  logic [D_SIZE-1:0] x_in,
  input  logic [S-1:0]      s_in,
  input  logic [2:0]        op_in,
  output logic [D_SIZE-1:0] y_out,
  output logic              zf_out,
  output logic              vf_out
);
  logic [2*D_SIZE-1:0] wide_l, wide_r, dup_l, dup_r;

  always_comb begin
    wide_l = {{D_SIZE{1'b0}}, x_in} << s_in;
    wide_r = {x_in, {D_SIZE{1'b0}}} >> s_in;
    dup_l  = {x_in, x_in} << s_in;
    dup_r  = {x_in, x_in} >> s_in;
    y_out  = x_in;
    vf_out = 1'b0;
    case (op_in)
      3'd0: begin y_out = wide_l[D_SIZE-1:0];        vf_out = |wide_l[2*D_SIZE-1:D_SIZE]; end
      3'd1: begin y_out = wide_r[2*D_SIZE-1:D_SIZE]; vf_out = |wide_r[D_SIZE-1:0];        end
      3'd2: y_out = $unsigned($signed(x_in) >>> s_in);
      3'd3: y_out = dup_l[2*D_SIZE-1:D_SIZE];
      3'd4: y_out = dup_r[D_SIZE-1:0];
      default: y_out = x_in;
    endcase
    if (rst_in) begin
      y_out  = '0;
      vf_out = 1'b0;
    end
    zf_out = ~|y_out;
  end
endmodule

// state | meaning
// EMPTY | response slot holds nothing
// FULL  | response slot holds a result waiting for rsp_ready_in
module barrelshifter_arbiter #(
  parameter int D_SIZE = 8,
  parameter int N_REQ  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [N_REQ-1:0]           req_valid_in,
  output logic [N_REQ-1:0]           req_ready_out,
  input  logic [N_REQ*D_SIZE-1:0]    req_x_in,
  input  logic [N_REQ*$clog2(D_SIZE)-1:0] req_s_in,
  input  logic [N_REQ*3-1:0]         req_op_in,
  output logic                       rsp_valid_out,
  input  logic                       rsp_ready_in,
  output logic [$clog2(N_REQ)-1:0]   rsp_id_out,
  output logic [D_SIZE-1:0]          rsp_y_out,
  output logic                       rsp_zf_out,
  output logic                       rsp_vf_out,
  output logic                       busy_out,
  output logic [CNT_W-1:0]           op_count_out
);
  localparam int S = $clog2(D_SIZE);
  localparam int I = $clog2(N_REQ);

  typedef enum logic {EMPTY, FULL} slot_state_t;
  slot_state_t state;

  logic [I-1:0]      win, sel;
  logic              any_valid, slot_free, grant;
  logic [D_SIZE-1:0] sh_x, sh_y;
  logic [S-1:0]      sh_s;
  logic [2:0]        sh_op;
  logic              sh_zf, sh_vf;

`ifdef BSARB_FIXED_PRIO_EN
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid_in[k]) begin
        win       = I'(k);
        any_valid = 1'b1;
      end
    end
  end
`else
  logic [I-1:0] rr_ptr;
  int           idx;

  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!any_valid && req_valid_in[idx]) begin
        win       = I'(idx);
        any_valid = 1'b1;
      end
    end
  end
`endif

  // Slot can take a new result if empty or being drained this same cycle.
  assign slot_free     = (state == EMPTY) || rsp_ready_in;
  assign grant         = any_valid && slot_free && !rst_in;
  assign req_ready_out = grant ? (N_REQ'(1) << win) : '0;
  assign sel           = (any_valid && slot_free) ? win : '0;

  assign sh_x  = req_x_in[int'(sel)*D_SIZE +: D_SIZE];
  assign sh_s  = req_s_in[int'(sel)*S +: S];
  assign sh_op = req_op_in[int'(sel)*3 +: 3];

  barrelshifter_comb_structural #(.D_SIZE(D_SIZE), .S(S)) u_shifter (
    .rst_in (rst_in),
    .x_in   (sh_x),
    .s_in   (sh_s),
    .op_in  (sh_op),
    .y_out  (sh_y),
    .zf_out (sh_zf),
    .vf_out (sh_vf)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= EMPTY;
      rsp_id_out   <= '0;
      rsp_y_out    <= '0;
      rsp_zf_out   <= 1'b0;
      rsp_vf_out   <= 1'b0;
      op_count_out <= '0;
`ifndef BSARB_FIXED_PRIO_EN
      rr_ptr       <= '0;
`endif
    end else if (grant) begin
      state        <= FULL;
      rsp_id_out   <= win;
      rsp_y_out    <= sh_y;
      rsp_zf_out   <= sh_zf;
      rsp_vf_out   <= sh_vf;
      op_count_out <= op_count_out + CNT_W'(1);
`ifndef BSARB_FIXED_PRIO_EN
      rr_ptr       <= (win == I'(N_REQ - 1)) ? '0 : win + I'(1);
`endif
    end else if (state == FULL && rsp_ready_in) begin
      state <= EMPTY;
    end
  end

  assign rsp_valid_out = (state == FULL);
  assign busy_out      = rsp_valid_out;
endmodule

// File: tb/tb_barrelshifter_arbiter.sv
// Directed bench for barrelshifter_arbiter: vector table plus handshake/reset/wrap sequences.
module tb_barrelshifter_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = 4'b1111;
  logic [3:0]  req_ready, w_req_ready;
  logic [31:0] req_x = '0;
  logic [11:0] req_s = '0;
  logic [11:0] req_op = '0;
  logic        rsp_ready = 1'b1;
  logic        rsp_valid, rsp_zf, rsp_vf, busy;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_y;
  logic [15:0] op_count;
  logic        w_rsp_valid, w_rsp_zf, w_rsp_vf, w_busy;
  logic [1:0]  w_rsp_id;
  logic [7:0]  w_rsp_y;
  logic [3:0]  w_op_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  barrelshifter_arbiter #(.D_SIZE(8), .N_REQ(4), .CNT_W(16)) dut (
    .clk_in(clk), .rst_in(rst), .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_x_in(req_x), .req_s_in(req_s), .req_op_in(req_op),
    .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready), .rsp_id_out(rsp_id),
    .rsp_y_out(rsp_y), .rsp_zf_out(rsp_zf), .rsp_vf_out(rsp_vf),
    .busy_out(busy), .op_count_out(op_count)
  );

  barrelshifter_arbiter #(.D_SIZE(8), .N_REQ(4), .CNT_W(4)) dut_w (
    .clk_in(clk), .rst_in(rst), .req_valid_in(req_valid), .req_ready_out(w_req_ready),
    .req_x_in(req_x), .req_s_in(req_s), .req_op_in(req_op),
    .rsp_valid_out(w_rsp_valid), .rsp_ready_in(rsp_ready), .rsp_id_out(w_rsp_id),
    .rsp_y_out(w_rsp_y), .rsp_zf_out(w_rsp_zf), .rsp_vf_out(w_rsp_vf),
    .busy_out(w_busy), .op_count_out(w_op_count)
  );

  typedef struct {
    int         id;
    logic [7:0] x;
    logic [2:0] s;
    logic [2:0] op;
    logic [7:0] y;
    logic       zf;
    logic       vf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [7:0] x, input logic [2:0] s, input logic [2:0] op);
    req_x[id*8 +: 8]  = x;
    req_s[id*3 +: 3]  = s;
    req_op[id*3 +: 3] = op;
  endtask

  initial begin
    logic [7:0] fair_y[4];
    logic [3:0] exp_grant;
    int         w;
    int         last_w;

    vecs[0] = '{2, 8'hA5, 3'd3, 3'd0, 8'h28, 1'b0, 1'b1};
    vecs[1] = '{1, 8'hA5, 3'd3, 3'd1, 8'h14, 1'b0, 1'b1};
    vecs[2] = '{3, 8'hA5, 3'd3, 3'd2, 8'hF4, 1'b0, 1'b0};
    vecs[3] = '{0, 8'hA5, 3'd3, 3'd3, 8'h2D, 1'b0, 1'b0};
    vecs[4] = '{1, 8'hA5, 3'd3, 3'd4, 8'hB4, 1'b0, 1'b0};
    vecs[5] = '{2, 8'h80, 3'd1, 3'd0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{0, 8'h01, 3'd1, 3'd1, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{3, 8'h3C, 3'd0, 3'd5, 8'h3C, 1'b0, 1'b0};
    vecs[8] = '{0, 8'h0F, 3'd7, 3'd3, 8'h87, 1'b0, 1'b0};
    vecs[9] = '{1, 8'h00, 3'd4, 3'd2, 8'h00, 1'b1, 1'b0};
    fair_y  = '{8'h11, 8'h44, 8'hCC, 8'h20};

    // Reset with all requesters valid.
    #1;
    for (int c = 0; c < 2; c++) begin
      check("reset_ready", 32'(req_ready), 32'h0);
      check("reset_ready_w", 32'(w_req_ready), 32'h0);
      step();
    end
    req_valid = 4'b0000;
    rst = 1'b0;
    step();
    check("post_reset_valid", 32'(rsp_valid), 32'h0);
    check("post_reset_busy", 32'(busy), 32'h0);
    check("post_reset_count", 32'(op_count), 32'h0);
    check("post_reset_y", 32'(rsp_y), 32'h0);

    // Single-request vectors, back-to-back drain-and-accept.
    rsp_ready = 1'b1;
    for (int v = 0; v < 10; v++) begin
      req_x  = $urandom;
      req_s  = 12'($urandom);
      req_op = 12'($urandom);
      set_req(vecs[v].id, vecs[v].x, vecs[v].s, vecs[v].op);
      req_valid = 4'(1 << vecs[v].id);
      #1;
      check("vec_grant", 32'(req_ready), 32'(1 << vecs[v].id));
      step();
      req_valid = 4'b0000;
      check("vec_valid", 32'(rsp_valid), 32'h1);
      check("vec_id", 32'(rsp_id), 32'(vecs[v].id));
      check("vec_y", 32'(rsp_y), 32'(vecs[v].y));
      check("vec_zf", 32'(rsp_zf), 32'(vecs[v].zf));
      check("vec_vf", 32'(rsp_vf), 32'(vecs[v].vf));
    end
    step();
    check("drain_valid", 32'(rsp_valid), 32'h0);
    check("vec_count", 32'(op_count), 32'd10);

    // Fairness from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 8'(8'h11 * (i + 1)), 3'(i), 3'd0);
    req_valid = 4'b1111;
    last_w = 0;
    for (int c = 0; c < 6; c++) begin
`ifdef BSARB_FIXED_PRIO_EN
      w = 0;
`else
      w = c % 4;
`endif
      exp_grant = 4'(1 << w);
      #1;
      check("fair_grant", 32'(req_ready), 32'(exp_grant));
      step();
      check("fair_id", 32'(rsp_id), 32'(w));
      check("fair_y", 32'(rsp_y), 32'(fair_y[w]));
      last_w = w;
    end
    check("fair_count", 32'(op_count), 32'd6);

    // Backpressure: slot full, consumer stalled for 5 cycles.
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    set_req(3, 8'h0F, 3'd1, 3'd0);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready", 32'(req_ready), 32'h0);
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_id", 32'(rsp_id), 32'(last_w));
      check("bp_y", 32'(rsp_y), 32'(fair_y[last_w]));
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_grant", 32'(req_ready), 32'h8);
    step();
    check("bp_new_id", 32'(rsp_id), 32'd3);
    check("bp_new_y", 32'(rsp_y), 32'h1E);
    check("bp_count", 32'(op_count), 32'd7);

    // Reset while a response is pending and rr_ptr sits at 2.
    req_valid = 4'b0010;
    #1;
    check("mid_grant", 32'(req_ready), 32'h2);
    step();
    check("mid_valid", 32'(rsp_valid), 32'h1);
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("mid_after_valid", 32'(rsp_valid), 32'h0);
    check("mid_after_count", 32'(op_count), 32'h0);
    check("mid_first_grant", 32'(req_ready), 32'h1);

    // Counter wrap on the CNT_W=4 instance.
    for (int c = 0; c < 17; c++) step();
    req_valid = 4'b0000;
    check("wrap_count_w", 32'(w_op_count), 32'd1);
    check("wrap_count", 32'(op_count), 32'd17);
    check("wrap_valid_w", 32'(w_rsp_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
